rx_pattern_checker: RTL
=======================

# rx_pattern_checker

Verifies the byte stream recovered by the deserializer (`Datarx`) against the incrementing-byte test pattern generated by `DataSource`. It sits directly downstream of the receiver in the loopback top, in the 50 MHz domain. It needs no knowledge of link latency or byte phase. It hunts for lock on the pattern, then counts mismatches against a free-running expected value, and reports lock state, per-byte error pulses and saturating good/error counters.

## Interface
- `LOCK_COUNT`, default 16: consecutive correct increments required to enter LOCKED (legal range 1–255).
- `LOSS_COUNT`, default 4: consecutive mismatches in LOCKED that force a return to HUNT (legal range 1–255).
- `CNT_W`, default 16: width of `err_count` and `good_count`.
- `clk`  in  1  50 MHz byte clock (same clock as `Datarx` output).
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  8  recovered byte, one new byte every `clk` cycle.
- `clear`  in  1  synchronous clear of `err_count` and `good_count`; no effect on state.
- `locked`  out  1  high while in LOCKED.
- `error`  out  1  one-cycle pulse per mismatching byte in LOCKED.
- `err_count`  out  CNT_W  saturating count of mismatches in LOCKED.
- `good_count`  out  CNT_W  saturating count of matching bytes in LOCKED.
- `state`  out  2  00 IDLE, 01 HUNT, 10 LOCKED (11 unused; decodes to IDLE).

## Operation
- `prev_q` holds the last sampled `data_in`. `exp_q` is the free-running expected byte. All byte arithmetic is mod 256, so 0xFF→0x00 is a correct increment.
- IDLE (after reset): capture `data_in` into `prev_q`, then go to HUNT. No comparison is made.
- HUNT:
  - Each cycle compare `data_in` with `prev_q+1`.
  - On a match, `run` increments. On a mismatch, `run` is set to 0.
  - `prev_q` is always updated.
  - When a match makes `run` equal `LOCK_COUNT`, go to LOCKED and load `exp_q = data_in+1`.
  - No error pulses and no counter updates occur in HUNT.
- LOCKED:
  - Each cycle compare `data_in` with `exp_q`. `exp_q` increments every cycle regardless of the result, so a single corrupted byte costs exactly one error.
  - On a match: `good_count` increments (saturating) and `miss` is set to 0.
  - On a mismatch: `error` pulses, `err_count` increments (saturating) and `miss` increments.
  - When `miss` reaches `LOSS_COUNT`, go to HUNT with `run`=0 and `prev_q=data_in`.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clear` and an increment in the same cycle: clear wins, so the counter reads 0. An `error` pulse in that cycle is still emitted.
- Reset mid-operation: every register returns to its reset value at once. The first byte after deassertion is handled as IDLE.

## Timing
- Reset values: `locked`=0, `error`=0, `err_count`=0, `good_count`=0, `state`=00, `run`=0, `miss`=0, `prev_q`=0, `exp_q`=0.
- All outputs are registered.
- `error` and the counter updates appear one cycle after the offending `data_in` is sampled.
- `locked`/`state`=10 asserts one cycle after the sampling edge of the `LOCK_COUNT`-th consecutive match. With a clean stream starting at reset release, that is cycle `LOCK_COUNT+2`.
- `locked` deasserts one cycle after the sampling edge of the `LOSS_COUNT`-th consecutive mismatch. That mismatch's `error` pulse occurs in the same cycle as the deassertion.
- The byte that causes the LOCKED→HUNT transition is the first `prev_q` reference in HUNT.

## Structure
- Shared package `dataloop_pkg`:
  - state encodings `ST_IDLE`, `ST_HUNT`, `ST_LOCKED`;
  - `BYTE_W`=8.
- One sub-module `sat_counter` (parameter `W`; inputs `clk`, `reset`, `clr`, `inc`; output `q`; clear has priority). It is instantiated twice, for `err_count` and `good_count`.
- FSM, `run`/`miss` counters and the compare logic live in `rx_pattern_checker`.

## Test plan
- Lock acquisition (defaults): release reset, drive 0x00,0x01,…,0x20 → `state` 00→01 after the first byte, `locked`=1 after 0x10 is sampled, `err_count`=0, no `error` pulses.
- Wrap: while locked, drive …0xFD,0xFE,0xFF,0x00,0x01 → no `error`, `good_count` +5.
- Single corruption: locked, drive 0x40,0x41,0xAA,0x43,0x44 → exactly one `error` pulse (for 0xAA), `err_count`=1, `locked` stays 1.
- Loss of lock: locked with expected 0x50, drive 0x00 four times → four `error` pulses, `locked`=0 on the fourth, `err_count`=4. Then drive 0x01… → relocks after 16 further matches.
- Saturation and clear: `CNT_W`=4, `LOSS_COUNT`=32, locked, alternate bad/good bytes for 20 errors → `err_count` holds 15. Then pulse `clear` coinciding with an error → `err_count`=0 and `error`=1 in that cycle.
- Reset mid-operation: assert `reset` while locked with `err_count`=3 → all outputs 0 and `state`=00 immediately. After release, a clean stream relocks per the lock-acquisition scenario.

Source files
------------

// File: rtl/dataloop_pkg.sv
// Shared types and constants for the loopback data path.
package dataloop_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned RUN_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_HUNT   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Next value of the incrementing pattern; wraps 0xFF -> 0x00.
  function automatic logic [BYTE_W-1:0] byte_inc(input logic [BYTE_W-1:0] b);
    return b + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that has priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  // Clear first, then increment unless already at the ceiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/rx_pattern_checker.sv
// Locks onto the incrementing-byte test pattern and counts mismatches once locked.
module rx_pattern_checker
  import dataloop_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              clear,
  output logic              locked,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  good_count,
  output logic [1:0]        state
);

  localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOSS_N = RUN_W'(LOSS_COUNT);

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RUN_W-1:0]   miss_q, miss_d;
  logic [BYTE_W-1:0]  prev_q, prev_d;
  logic [BYTE_W-1:0]  exp_q, exp_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;

  logic               hunt_match_c;
  logic               lock_match_c;
  logic [RUN_W-1:0]   run_inc_c;
  logic [RUN_W-1:0]   miss_inc_c;
  logic               err_inc_c;
  logic               good_inc_c;

  // State, tracking registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      miss_q   <= '0;
      prev_q   <= '0;
      exp_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      prev_q   <= prev_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  // Next-state, compare and counter-increment decode.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    miss_d       = miss_q;
    prev_d       = prev_q;
    exp_d        = exp_q;
    err_inc_c    = 1'b0;
    good_inc_c   = 1'b0;
    hunt_match_c = (data_in == byte_inc(prev_q));
    lock_match_c = (data_in == exp_q);
    run_inc_c    = run_q + RUN_W'(1);
    miss_inc_c   = miss_q + RUN_W'(1);

    case (state_q)
      ST_HUNT: begin
        prev_d = data_in;
        if (hunt_match_c) begin
          run_d = run_inc_c;
          if (run_inc_c == LOCK_N) begin
            state_d = ST_LOCKED;
            exp_d   = byte_inc(data_in);
            miss_d  = '0;
          end
        end else begin
          run_d = '0;
        end
      end

      ST_LOCKED: begin
        // Expected value free-runs so one corrupted byte costs one error.
        exp_d = byte_inc(exp_q);
        if (lock_match_c) begin
          good_inc_c = 1'b1;
          miss_d     = '0;
        end else begin
          err_inc_c = 1'b1;
          miss_d    = miss_inc_c;
          if (miss_inc_c == LOSS_N) begin
            state_d = ST_HUNT;
            run_d   = '0;
            miss_d  = '0;
            prev_d  = data_in;
          end
        end
      end

      default: begin
        // IDLE and the unused encoding: seed the reference byte only.
        prev_d  = data_in;
        run_d   = '0;
        miss_d  = '0;
        state_d = ST_HUNT;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    error_d  = err_inc_c;
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (err_inc_c),
    .q     (err_count)
  );

  sat_counter #(.W(CNT_W)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (good_inc_c),
    .q     (good_count)
  );

  assign locked = locked_q;
  assign error  = error_q;
  assign state  = state_q;

endmodule
